// File: rtl/mult_fp_pipe_pkg.sv
// Shared floating-point constants and helpers for the fp block family.
// Everything is derived from the exponent/mantissa widths so later fp blocks can reuse it.
package mult_fp_pipe_pkg;

  typedef enum logic [1:0] {
    CLS_NORM = 2'd0,
    CLS_ZERO = 2'd1,
    CLS_INF  = 2'd2,
    CLS_NAN  = 2'd3
  } cls_t;

  // Bit positions inside the 4-bit flags word {nan, ovf, unf, inexact}.
  localparam int FLAG_NAN     = 3;
  localparam int FLAG_OVF     = 2;
  localparam int FLAG_UNF     = 1;
  localparam int FLAG_INEXACT = 0;

  function automatic int fp_bias(input int exp_w);
    return (1 << (exp_w - 1)) - 1;
  endfunction

  function automatic int fp_exp_max(input int exp_w);
    return (1 << exp_w) - 1;
  endfunction

  function automatic int fp_sign_pos(input int exp_w, input int man_w);
    return exp_w + man_w;
  endfunction

endpackage

// File: rtl/mult_fp_pipe_round_norm.sv
// Final stage of the multiplier: normalise the raw mantissa product, round, and pack.
// Purely combinational; special operand classes bypass the arithmetic path.
module fp_round_norm
  import mult_fp_pipe_pkg::*;
#(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23
) (
  input  logic [2*MAN_W+1:0]      prod,
  input  logic signed [EXP_W+1:0] exp_in,
  input  logic                    sign,
  input  logic                    rnd_mode,
  input  logic [1:0]              cls,
  output logic [EXP_W+MAN_W:0]    word,
  output logic [3:0]              flags
);

  localparam int EW = EXP_W + 2;
  localparam logic signed [EW-1:0] EMAX  = EW'(fp_exp_max(EXP_W));
  localparam logic signed [EW-1:0] EZERO = '0;

  logic                   top;
  logic [2*MAN_W:0]       norm;
  logic [MAN_W-1:0]       mant;
  logic [MAN_W-1:0]       mant_r;
  logic                   guard;
  logic                   sticky;
  logic                   inexact;
  logic                   round_up;
  logic                   carry;
  logic signed [EW-1:0]   e1;
  logic signed [EW-1:0]   e2;

  always_comb begin
    // norm holds the bits below the leading one, left-aligned.
    top      = prod[2*MAN_W+1];
    norm     = top ? prod[2*MAN_W:0] : {prod[2*MAN_W-1:0], 1'b0};
    e1       = exp_in + EW'(top);
    mant     = norm[2*MAN_W:MAN_W+1];
    guard    = norm[MAN_W];
    sticky   = |norm[MAN_W-1:0];
    inexact  = guard | sticky;
    round_up = !rnd_mode && guard && (sticky || mant[0]);
    {carry, mant_r} = {1'b0, mant} + (MAN_W+1)'(round_up);
    e2       = carry ? e1 + EW'(1) : e1;

    word  = '0;
    flags = '0;
    case (cls_t'(cls))
      CLS_NAN: begin
        word = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};
        flags[FLAG_NAN] = 1'b1;
      end
      CLS_INF:  word = {sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
      CLS_ZERO: word = {sign, {(EXP_W+MAN_W){1'b0}}};
      default: begin
        if (e2 >= EMAX) begin
          word = {sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
          flags[FLAG_OVF]     = 1'b1;
          flags[FLAG_INEXACT] = 1'b1;
        end else if (e2 <= EZERO) begin
          word = {sign, {(EXP_W+MAN_W){1'b0}}};
          flags[FLAG_UNF]     = 1'b1;
          flags[FLAG_INEXACT] = 1'b1;
        end else begin
          word = {sign, e2[EXP_W-1:0], mant_r};
          flags[FLAG_INEXACT] = inexact;
        end
      end
    endcase
  end

endmodule

// File: rtl/mult_fp_pipe.sv
// Three-stage pipelined floating-point multiplier: classify/exponent, mantissa product, round/pack.
// Handshake: data crosses a port on a rising edge where valid and ready are both high; valid never waits on ready.
module mult_fp_pipe
  import mult_fp_pipe_pkg::*;
#(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [EXP_W+MAN_W:0] a,
  input  logic [EXP_W+MAN_W:0] b,
  input  logic                 rnd_mode,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [EXP_W+MAN_W:0] m,
  output logic [3:0]           flags
);

  localparam int EW = EXP_W + 2;
  localparam int PW = 2*MAN_W + 2;
  localparam logic signed [EW-1:0] BIAS_E = EW'(fp_bias(EXP_W));

  logic                 sa, sb;
  logic [EXP_W-1:0]     ea, eb;
  logic [MAN_W-1:0]     fa, fb;
  logic                 za, zb, ia, ib, na, nb;
  cls_t                 cls_d;
  logic signed [EW-1:0] esum_d;

  logic                 adv3, en2, en1;

  logic                 s1_v, s1_sign, s1_rnd;
  logic signed [EW-1:0] s1_e;
  logic [MAN_W:0]       s1_ma, s1_mb;
  cls_t                 s1_cls;

  logic                 s2_v, s2_sign, s2_rnd;
  logic signed [EW-1:0] s2_e;
  logic [PW-1:0]        s2_prod;
  cls_t                 s2_cls;

  logic [EXP_W+MAN_W:0] res_word;
  logic [3:0]           res_flags;

  // Stage 1: unpack and classify; exp field 0 flushes to zero.
  always_comb begin
    {sa, ea, fa} = a;
    {sb, eb, fb} = b;
    za = (ea == '0);
    zb = (eb == '0);
    ia = (&ea) && (fa == '0);
    ib = (&eb) && (fb == '0);
    na = (&ea) && (fa != '0);
    nb = (&eb) && (fb != '0);
    if (na || nb || (ia && zb) || (ib && za)) cls_d = CLS_NAN;
    else if (ia || ib)                        cls_d = CLS_INF;
    else if (za || zb)                        cls_d = CLS_ZERO;
    else                                      cls_d = CLS_NORM;
    esum_d = EW'(ea) + EW'(eb) - BIAS_E;
  end

  // A stage loads when the stage ahead moves or is empty, so bubbles close up under a stall.
  assign in_ready = !(out_valid && !out_ready);
  assign adv3     = in_ready;
  assign en2      = adv3 || !s2_v;
  assign en1      = en2 || !s1_v;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_v      <= 1'b0;
      s2_v      <= 1'b0;
      out_valid <= 1'b0;
      m         <= '0;
      flags     <= '0;
    end else begin
      if (en1) s1_v <= in_valid && in_ready;
      if (en2) s2_v <= s1_v;
      if (adv3) begin
        out_valid <= s2_v;
        if (s2_v) begin
          m     <= res_word;
          flags <= res_flags;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (en1) begin
      s1_sign <= sa ^ sb;
      s1_e    <= esum_d;
      s1_ma   <= {1'b1, fa};
      s1_mb   <= {1'b1, fb};
      s1_rnd  <= rnd_mode;
      s1_cls  <= cls_d;
    end
    if (en2) begin
      s2_sign <= s1_sign;
      s2_e    <= s1_e;
      s2_prod <= PW'(s1_ma) * PW'(s1_mb);
      s2_rnd  <= s1_rnd;
      s2_cls  <= s1_cls;
    end
  end

  fp_round_norm #(.EXP_W(EXP_W), .MAN_W(MAN_W)) u_round_norm (
    .prod     (s2_prod),
    .exp_in   (s2_e),
    .sign     (s2_sign),
    .rnd_mode (s2_rnd),
    .cls      (s2_cls),
    .word     (res_word),
    .flags    (res_flags)
  );

endmodule

// File: tb/tb_mult_fp_pipe.sv
// Directed bench for mult_fp_pipe (binary32 layout): arithmetic, rounding, specials, stall and reset.
module tb_mult_fp_pipe;

  logic        clk, rst, in_valid, in_ready, rnd_mode, out_valid, out_ready;
  logic [31:0] a, b, m;
  logic [3:0]  flags;

  int n_cmp = 0;
  int n_err = 0;

  logic [31:0] exp_q[$];
  logic [3:0]  expf_q[$];

  typedef struct packed {
    logic [31:0] a;
    logic [31:0] b;
    logic        r;
    logic [31:0] m;
    logic [3:0]  f;
  } vec_t;

  vec_t vecs [18];

  mult_fp_pipe #(.EXP_W(8), .MAN_W(23)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .rnd_mode  (rnd_mode),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .m         (m),
    .flags     (flags)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    n_err++;
    $display("FAIL watchdog: got no finish by 200000, want finish");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $fatal(1, "watchdog expired");
  end

  // ---------------- driver ----------------
  // One operation through an otherwise idle pipe; lat counts edges from accept (inclusive) to out_valid.
  task automatic send_op(input logic [31:0] xa, input logic [31:0] xb, input logic r,
                         output logic [31:0] rm, output logic [3:0] rf, output int lat);
    @(negedge clk);
    a = xa; b = xb; rnd_mode = r; in_valid = 1'b1; out_ready = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 20) begin
      @(posedge clk);
      #1;
      lat++;
    end
    rm = m;
    rf = flags;
    if (!out_valid) lat = -1;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; a = '0; b = '0; rnd_mode = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL rst_out_valid: got %b want 0", out_valid); end
    n_cmp++; if (m !== 32'h0) begin n_err++; $display("FAIL rst_m: got %h want 00000000", m); end
    n_cmp++; if (flags !== 4'h0) begin n_err++; $display("FAIL rst_flags: got %h want 0", flags); end
    n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL rst_in_ready: got %b want 1", in_ready); end
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL post_rst_out_valid: got %b want 0", out_valid); end
    n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL post_rst_in_ready: got %b want 1", in_ready); end
  endtask

  task automatic run_range(input string tag, input int lo, input int hi);
    logic [31:0] rm;
    logic [3:0]  rf;
    int          lat;
    for (int i = lo; i <= hi; i++) begin
      send_op(vecs[i].a, vecs[i].b, vecs[i].r, rm, rf, lat);
      n_cmp++;
      if (lat != 3) begin n_err++; $display("FAIL %s_latency[%0d]: got %0d want 3", tag, i, lat); end
      n_cmp++;
      if (rm !== vecs[i].m) begin n_err++; $display("FAIL %s_m[%0d]: got %h want %h", tag, i, rm, vecs[i].m); end
      n_cmp++;
      if (rf !== vecs[i].f) begin n_err++; $display("FAIL %s_flags[%0d]: got %h want %h", tag, i, rf, vecs[i].f); end
    end
  endtask

  task automatic test_basic();
    run_range("basic", 0, 0);
    run_range("basic", 16, 17);
  endtask

  task automatic test_rounding();
    run_range("round", 1, 6);
  endtask

  task automatic test_ovf_unf();
    run_range("range", 7, 9);
  endtask

  task automatic test_specials();
    run_range("special", 10, 15);
  endtask

  task automatic test_back_to_back();
    int ops [4] = '{0, 1, 16, 17};
    int got   = 0;
    int stall = 0;
    int cyc   = 0;
    @(posedge clk);
    #1 out_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      exp_q.push_back(vecs[ops[i]].m);
      expf_q.push_back(vecs[ops[i]].f);
    end
    fork
      begin
        for (int i = 0; i < 4; i++) begin
          int wait_n = 0;
          @(negedge clk);
          a = vecs[ops[i]].a; b = vecs[ops[i]].b; rnd_mode = vecs[ops[i]].r; in_valid = 1'b1;
          while (!in_ready && wait_n < 50) begin
            @(negedge clk);
            wait_n++;
          end
          @(posedge clk);
        end
        @(negedge clk);
        in_valid = 1'b0;
      end
      begin
        while (got < 4 && cyc < 200) begin
          @(negedge clk);
          cyc++;
          if (cyc == 9) out_ready = 1'b1;
          if (out_valid && !out_ready) begin
            stall++;
            n_cmp++;
            if (in_ready !== 1'b0) begin n_err++; $display("FAIL b2b_stall_in_ready: got %b want 0", in_ready); end
            n_cmp++;
            if (m !== exp_q[0]) begin n_err++; $display("FAIL b2b_stall_m: got %h want %h", m, exp_q[0]); end
          end else if (out_valid && out_ready) begin
            logic [31:0] em;
            logic [3:0]  ef;
            em = exp_q.pop_front();
            ef = expf_q.pop_front();
            n_cmp++;
            if (m !== em) begin n_err++; $display("FAIL b2b_m[%0d]: got %h want %h", got, m, em); end
            n_cmp++;
            if (flags !== ef) begin n_err++; $display("FAIL b2b_flags[%0d]: got %h want %h", got, flags, ef); end
            got++;
          end
        end
      end
    join
    n_cmp++;
    if (got != 4) begin n_err++; $display("FAIL b2b_count: got %0d want 4", got); end
    n_cmp++;
    if (stall != 5) begin n_err++; $display("FAIL b2b_stall_cycles: got %0d want 5", stall); end
    exp_q.delete();
    expf_q.delete();
  endtask

  task automatic test_reset_midflight();
    logic [31:0] rm;
    logic [3:0]  rf;
    int          lat;
    int          stale = 0;
    @(negedge clk);
    out_ready = 1'b1; a = vecs[0].a; b = vecs[0].b; rnd_mode = 1'b0; in_valid = 1'b1;
    @(posedge clk);
    #1 a = vecs[16].a; b = vecs[16].b;
    @(posedge clk);
    #1 a = vecs[17].a; b = vecs[17].b;
    @(posedge clk);
    #1 in_valid = 1'b0;
    n_cmp++;
    if (out_valid !== 1'b1) begin n_err++; $display("FAIL mid_pre_valid: got %b want 1", out_valid); end
    #2 rst = 1'b1;
    #1;
    n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL mid_rst_out_valid: got %b want 0", out_valid); end
    n_cmp++; if (m !== 32'h0) begin n_err++; $display("FAIL mid_rst_m: got %h want 00000000", m); end
    n_cmp++; if (flags !== 4'h0) begin n_err++; $display("FAIL mid_rst_flags: got %h want 0", flags); end
    n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL mid_rst_in_ready: got %b want 1", in_ready); end
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    repeat (12) begin
      @(posedge clk);
      #1;
      if (out_valid) stale++;
    end
    n_cmp++;
    if (stale != 0) begin n_err++; $display("FAIL mid_stale: got %0d stale results want 0", stale); end
    send_op(vecs[7].a, vecs[7].b, vecs[7].r, rm, rf, lat);
    n_cmp++; if (lat != 3) begin n_err++; $display("FAIL mid_post_latency: got %0d want 3", lat); end
    n_cmp++; if (rm !== vecs[7].m) begin n_err++; $display("FAIL mid_post_m: got %h want %h", rm, vecs[7].m); end
    n_cmp++; if (rf !== vecs[7].f) begin n_err++; $display("FAIL mid_post_flags: got %h want %h", rf, vecs[7].f); end
  endtask

  // ---------------- main sequence / report ----------------
  initial begin
    vecs = '{
      '{32'h40000000, 32'h40400000, 1'b0, 32'h40C00000, 4'h0},  // 2*3
      '{32'h3FC00001, 32'h3FC00000, 1'b0, 32'h40100001, 4'h1},  // RNE rounds up
      '{32'h3FC00001, 32'h3FC00000, 1'b1, 32'h40100000, 4'h1},  // truncate
      '{32'h3FB4F93B, 32'h3FB510AC, 1'b0, 32'h40000000, 4'h1},  // rounding carry-out
      '{32'h3FB4F93B, 32'h3FB510AC, 1'b1, 32'h3FFFFFFF, 4'h1},
      '{32'h3F800001, 32'h3FC00000, 1'b0, 32'h3FC00002, 4'h1},  // tie, odd lsb -> up
      '{32'h3F800003, 32'h3FC00000, 1'b0, 32'h3FC00004, 4'h1},  // tie, even lsb -> stay
      '{32'h7F000000, 32'h40000000, 1'b0, 32'h7F800000, 4'h5},  // overflow
      '{32'h00800000, 32'h00800000, 1'b0, 32'h00000000, 4'h3},  // underflow
      '{32'h7F000000, 32'h3F800000, 1'b0, 32'h7F000000, 4'h0},  // largest exponent
      '{32'h7F800000, 32'h00000000, 1'b0, 32'h7FC00000, 4'h8},  // inf*0
      '{32'hFF800000, 32'h40000000, 1'b0, 32'hFF800000, 4'h0},  // -inf*2
      '{32'h00000000, 32'hC0400000, 1'b0, 32'h80000000, 4'h0},  // signed zero
      '{32'h7FC00001, 32'h3F800000, 1'b0, 32'h7FC00000, 4'h8},  // NaN operand
      '{32'hFF800000, 32'hFF800000, 1'b0, 32'h7F800000, 4'h0},  // inf*inf
      '{32'h00400000, 32'h40000000, 1'b0, 32'h00000000, 4'h0},  // subnormal flush
      '{32'hC0000000, 32'h40400000, 1'b0, 32'hC0C00000, 4'h0},  // -2*3
      '{32'h3F800000, 32'h3F800000, 1'b0, 32'h3F800000, 4'h0}   // 1*1
    };
    test_reset();
    test_basic();
    test_rounding();
    test_ovf_unf();
    test_specials();
    test_back_to_back();
    test_reset_midflight();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/mult_fp_pipe.md
MULT_FP_PIPE -- requirements
Module: mult_fp_pipe

Interface
REQ-001 Parameter EXP_W, default 8, exponent field width.
REQ-002 Parameter MAN_W, default 23, stored mantissa field width; word width W = 1+EXP_W+MAN_W.
REQ-003 clk  input  1  single clock, all state on rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 in_valid  input  1  operand pair a/b is presented.
REQ-006 in_ready  output  1  block accepts the pair this cycle.
REQ-007 a  input  W  operand A, IEEE-style {sign, exponent, mantissa}.
REQ-008 b  input  W  operand B, same format.
REQ-009 rnd_mode  input  1  0 = round-nearest-even, 1 = truncate; sampled with operands.
REQ-010 out_valid  output  1  m and flags hold a result.
REQ-011 out_ready  input  1  consumer takes the result this cycle.
REQ-012 m  output  W  product a*b.
REQ-013 flags  output  4  {nan, ovf, unf, inexact} for the result on m.

Function
REQ-014 Transfer occurs on a rising edge with valid&ready high at the same port; no other edge moves data.
REQ-015 Three-stage pipeline, fixed latency 3 cycles from input transfer to out_valid when unstalled: S1 unpack/classify/exponent sum; S2 (MAN_W+1)x(MAN_W+1) mantissa product; S3 normalise/round/pack.
REQ-016 Throughput one result per cycle while out_ready=1; results leave in acceptance order.
REQ-017 Stall: when out_valid=1 and out_ready=0, all stages hold and in_ready=0; in_ready = !(out_valid & !out_ready); held m/flags stay stable.
REQ-018 Bubbles (stage valid=0) advance even while output stalls only if the stage ahead is empty; no result is dropped or duplicated.
REQ-019 Bias = 2^(EXP_W-1)-1; exponent arithmetic in EXP_W+2-bit signed; e = ea+eb-bias.
REQ-020 Product bit 2*MAN_W+1 set -> shift right 1, e+1.
REQ-021 RNE uses guard, round, sticky bits; tie rounds to even mantissa LSB; rounding carry-out renormalises (e+1, mantissa 0).
REQ-022 inexact = any discarded product bit nonzero (both modes).
REQ-023 Sign = sa XOR sb for all non-NaN results, including zero and infinity.
REQ-024 Zero or subnormal (exp field 0) operands are treated as zero (flush); finite*zero -> signed zero, flags 0.
REQ-025 Either operand NaN, or infinity*zero -> canonical NaN {0, all-ones exp, mantissa MSB 1, rest 0}, nan=1.
REQ-026 Infinity*finite-nonzero or infinity*infinity -> signed infinity, flags 0.
REQ-027 Final e >= 2^EXP_W-1 -> signed infinity, ovf=1, inexact=1.
REQ-028 Final e <= 0 -> signed zero (no subnormal output), unf=1, inexact=1.

Reset
REQ-029 rst high clears all stage-valid bits immediately; out_valid=0, m=0, flags=0; in_ready=1 during and after reset.
REQ-030 rst mid-operation discards all in-flight results; first post-reset output comes only from a post-reset input.

Structure
REQ-031 Shared include file holds bias, canonical-NaN and field-position localparams as functions of EXP_W/MAN_W, reused by later fp blocks.
REQ-032 Stage S3 is a sub-module fp_round_norm (product, exponent, sign, rnd_mode in; packed word and flags out), combinational.
REQ-033 Datapath flops have no reset; only valid bits and output registers reset.

Verification (EXP_W=8, MAN_W=23)
REQ-034 a=0x40000000, b=0x40400000, out_ready=1 -> m=0x40C00000, flags=0, out_valid exactly 3 cycles after accept.
REQ-035 a=0x3FC00001, b=0x3FC00000: rnd_mode=0 -> 0x40100001, inexact=1; rnd_mode=1 -> 0x40100000, inexact=1.
REQ-036 a=0x7F000000, b=0x40000000 -> 0x7F800000, ovf=1; a=0x00800000, b=0x00800000 -> 0x00000000, unf=1.
REQ-037 a=0x7F800000, b=0x00000000 -> 0x7FC00000, nan=1; a=0xFF800000, b=0x40000000 -> 0xFF800000.
REQ-038 Four back-to-back inputs, out_ready low 5 cycles -> in_ready falls, m stable, all four results emerge in order, none lost.
REQ-039 rst pulse with 2 ops in flight -> out_valid=0 immediately, no stale result appears afterward.
